esram_pkt_writer: RTL and testbench
===================================

// Module: esram_pkt_writer
// PURPOSE
//  Consumes the registered Ethernet ingress stream (reg_in_* from the datamover-domain pipe stage).
//  Packs each flit into a 520-bit eSRAM word and writes it into a circular packet buffer.
//  Emits one descriptor (start address, length in flits) per fully-stored packet.
//  Drops packets whole when buffer space or descriptor credit is lacking; drives esram_pkt_buf_wr* directly.
// PARAMETERS
//  AWIDTH         17   eSRAM word address width; buffer depth = 2**AWIDTH flits
//  MAX_PKT_FLITS  150  max flits per packet (9600B jumbo / 64B); longer packets are aborted
//  CNT_WIDTH      32   width of statistics counters
// PORTS
//  clk                      in   1        datamover clock
//  rst                      in   1        synchronous active-high reset
//  in_sop                   in   1        start of packet
//  in_eop                   in   1        end of packet
//  in_data                  in   512      flit payload
//  in_empty                 in   6        empty bytes on eop flit
//  in_valid                 in   1        flit valid; no backpressure, every valid flit must be consumed
//  esram_pkt_buf_wren       out  1        eSRAM write enable
//  esram_pkt_buf_wraddress  out  AWIDTH   eSRAM write address
//  esram_pkt_buf_wrdata     out  520      {sop,eop,empty[5:0],data[511:0]}
//  free_valid               in   1        consumer returns buffer space
//  free_len                 in   AWIDTH   flits returned when free_valid
//  desc_almost_full         in   1        descriptor queue cannot accept a new packet
//  desc_valid               out  1        descriptor strobe, one cycle
//  desc_addr                out  AWIDTH   packet start address
//  desc_len                 out  8        packet length in flits (1..MAX_PKT_FLITS)
//  pkt_cnt                  out  CNT_WIDTH packets stored
//  drop_cnt                 out  CNT_WIDTH packets dropped (space/credit)
//  err_cnt                  out  CNT_WIDTH malformed/oversize events
// BEHAVIOUR
//  Reset: all outputs 0; wr_ptr=0, pkt_start=0, occupancy=0, state=IDLE. Reset mid-packet discards it; no descriptor.
//  Latency: wren/wraddress/wrdata registered, 1 cycle after the accepted input flit.
//   desc_valid asserts in the same cycle as the eop flit's wren.
//  wrdata[519]=sop, [518]=eop, [517:512]=empty, [511:0]=data.
//  FSM:
//   IDLE : valid&sop -> admit iff (2**AWIDTH - occupancy) >= MAX_PKT_FLITS and !desc_almost_full.
//          Admit: write at wr_ptr, pkt_start=wr_ptr, len=1; eop ? emit desc, stay IDLE : WRITE.
//          Refuse: drop_cnt++ when the packet ends; eop ? stay IDLE : DROP.
//          valid&!sop: discard flit, err_cnt++, stay IDLE.
//   WRITE: valid&!sop: write, len++; on eop: emit desc (addr=pkt_start, len), pkt_cnt++, -> IDLE.
//          valid&sop (missing eop): rewind wr_ptr=pkt_start, occupancy -= len, err_cnt++,
//            then evaluate the new flit exactly as in IDLE in the same cycle.
//          len would exceed MAX_PKT_FLITS: rewind as above, err_cnt++, -> DROP (eop -> IDLE).
//   DROP : discard flits until valid&eop -> IDLE. valid&sop in DROP: re-evaluate as IDLE.
//  Pointer: wr_ptr increments mod 2**AWIDTH per written flit; wraps 2**AWIDTH-1 -> 0.
//   Packets may straddle the wrap; desc_len counts flits, not address span.
//  Occupancy: +1 per written flit, -free_len on free_valid, -len on rewind; all same-cycle events
//   are netted in one update. free_len beyond occupancy is a protocol error: clamp to 0, err_cnt++.
//  desc_almost_full is sampled only at sop; mid-packet assertion does not abort.
//  Counters saturate at all-ones.
// TESTING
//  1-flit pkt (sop&eop, empty=10) at reset -> next cycle wren=1, addr=0, wrdata[518]=1, [517:512]=10,
//   desc_valid=1, addr=0, len=1; pkt_cnt=1.
//  Back-to-back 3-flit packets -> addrs 0,1,2,3,4,5; descs (0,3),(3,3); no idle cycles are required.
//  Preload wr_ptr near 2**17-2 via traffic+free; 4-flit pkt -> addrs 1FFFE,1FFFF,0,1; desc (1FFFE,4).
//  Occupancy > 2**17-150 at sop -> no wren for whole pkt, drop_cnt+1. free_valid frees space; next pkt stored.
//  desc_almost_full=1 at sop -> drop. Assert it mid-pkt of an admitted packet -> pkt still stored.
//  sop inside WRITE after 2 flits -> new pkt written from old pkt_start, err_cnt=1. 151-flit pkt -> aborted, err_cnt+1.
//  rst asserted mid-packet -> outputs 0 next cycle; next pkt lands at addr 0.

Source files
------------

// File: rtl/esram_pkt_writer_if.sv
// Ingress flit stream, eSRAM write port, buffer-free return and descriptor
// channel of the eSRAM packet writer.
interface esram_pkt_writer_if #(
  parameter int unsigned AWIDTH = 17
);
  logic              in_sop;
  logic              in_eop;
  logic [511:0]      in_data;
  logic [5:0]        in_empty;
  logic              in_valid;
  logic              esram_pkt_buf_wren;
  logic [AWIDTH-1:0] esram_pkt_buf_wraddress;
  logic [519:0]      esram_pkt_buf_wrdata;
  logic              free_valid;
  logic [AWIDTH-1:0] free_len;
  logic              desc_almost_full;
  logic              desc_valid;
  logic [AWIDTH-1:0] desc_addr;
  logic [7:0]        desc_len;

  modport master (
    output in_sop, in_eop, in_data, in_empty, in_valid,
    output free_valid, free_len, desc_almost_full,
    input  esram_pkt_buf_wren, esram_pkt_buf_wraddress, esram_pkt_buf_wrdata,
    input  desc_valid, desc_addr, desc_len
  );

  modport slave (
    input  in_sop, in_eop, in_data, in_empty, in_valid,
    input  free_valid, free_len, desc_almost_full,
    output esram_pkt_buf_wren, esram_pkt_buf_wraddress, esram_pkt_buf_wrdata,
    output desc_valid, desc_addr, desc_len
  );
endinterface

// File: rtl/esram_pkt_writer.sv
// Packs ingress flits into 520-bit eSRAM words in a circular packet buffer,
// emits one descriptor per stored packet and drops packets whole when short of space/credit.
module esram_pkt_writer #(
  parameter int unsigned AWIDTH        = 17,
  parameter int unsigned MAX_PKT_FLITS = 150,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  esram_pkt_writer_if.slave    bus,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [AWIDTH:0] ADMIT_LIMIT = (AWIDTH+1)'(2**AWIDTH - MAX_PKT_FLITS);
  localparam logic [7:0]      MAX_LEN     = 8'(MAX_PKT_FLITS);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t            state;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] pkt_start;
  logic [AWIDTH:0]   occ;
  logic [7:0]        len;
  logic              drop_pend;

  logic              rewind, new_pkt, cont_write, abort, stray, drop_end;
  logic              admit, refuse, wr, free_err;
  logic [AWIDTH:0]   held, occ_next, len_ext, wr_ext, free_ext;
  logic [AWIDTH-1:0] base_ptr;
  logic [1:0]        err_inc, drop_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    rewind     = 1'b0;
    new_pkt    = 1'b0;
    cont_write = 1'b0;
    abort      = 1'b0;
    stray      = 1'b0;
    drop_end   = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        new_pkt = bus.in_sop;
        stray   = !bus.in_sop;
      end
      WRITE: if (bus.in_valid) begin
        if (bus.in_sop) begin
          rewind  = 1'b1;
          new_pkt = 1'b1;
        end else if (len == MAX_LEN) begin
          rewind = 1'b1;
          abort  = 1'b1;
        end else begin
          cont_write = 1'b1;
        end
      end
      DROP: if (bus.in_valid) begin
        new_pkt  = bus.in_sop;
        drop_end = drop_pend & (bus.in_sop | bus.in_eop);
      end
      default: ;
    endcase

    // A truncated packet is rewound first, so a new sop in the same cycle
    // is admitted against the space the abandoned flits gave back.
    len_ext  = {{(AWIDTH+1-8){1'b0}}, len};
    wr_ext   = '0;
    free_ext = {1'b0, bus.free_len};
    held     = occ - (rewind ? len_ext : '0);
    base_ptr = rewind ? pkt_start : wr_ptr;
    admit    = new_pkt && (held <= ADMIT_LIMIT) && !bus.desc_almost_full;
    refuse   = new_pkt && !admit;
    wr       = admit | cont_write;
    wr_ext[0] = wr;

    // Over-returned space empties the buffer bookkeeping; this cycle's write still counts.
    free_err = bus.free_valid && (free_ext > held);
    if (!bus.free_valid)  occ_next = held + wr_ext;
    else if (free_err)    occ_next = wr_ext;
    else                  occ_next = held - free_ext + wr_ext;

    err_inc  = 2'(stray) + 2'(rewind) + 2'(free_err);
    drop_inc = 2'(drop_end) + 2'(refuse & bus.in_eop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      pkt_start <= '0;
      occ       <= '0;
      len       <= '0;
      drop_pend <= 1'b0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      err_cnt   <= '0;
      bus.esram_pkt_buf_wren      <= 1'b0;
      bus.esram_pkt_buf_wraddress <= '0;
      bus.esram_pkt_buf_wrdata    <= '0;
      bus.desc_valid              <= 1'b0;
      bus.desc_addr               <= '0;
      bus.desc_len                <= '0;
    end else begin
      bus.esram_pkt_buf_wren <= wr;
      if (wr) begin
        bus.esram_pkt_buf_wraddress <= base_ptr;
        bus.esram_pkt_buf_wrdata    <= {bus.in_sop, bus.in_eop, bus.in_empty, bus.in_data};
      end
      bus.desc_valid <= wr & bus.in_eop;
      if (wr && bus.in_eop) begin
        bus.desc_addr <= admit ? base_ptr : pkt_start;
        bus.desc_len  <= admit ? 8'd1 : len + 8'd1;
      end

      wr_ptr <= base_ptr + AWIDTH'(wr);
      occ    <= occ_next;
      if (admit) begin
        pkt_start <= base_ptr;
        len       <= 8'd1;
      end else if (cont_write) begin
        len <= len + 8'd1;
      end

      if (new_pkt)                         drop_pend <= refuse & !bus.in_eop;
      else if (bus.in_valid && bus.in_eop) drop_pend <= 1'b0;

      if (new_pkt)
        state <= bus.in_eop ? IDLE : (admit ? WRITE : DROP);
      else if (cont_write)
        state <= bus.in_eop ? IDLE : WRITE;
      else if (abort)
        state <= bus.in_eop ? IDLE : DROP;
      else if (state == DROP && bus.in_valid && bus.in_eop)
        state <= IDLE;

      pkt_cnt  <= sat_add(pkt_cnt, 2'(wr & bus.in_eop));
      drop_cnt <= sat_add(drop_cnt, drop_inc);
      err_cnt  <= sat_add(err_cnt, err_inc);
    end
  end

endmodule

// File: tb/tb_esram_pkt_writer.sv
// Scoreboard bench for esram_pkt_writer: a packet-level reference model queues
// expected eSRAM writes and descriptors; a negedge monitor pops and compares them.
module tb_esram_pkt_writer;
  // Small buffer depth so pointer wrap and buffer-full are reachable quickly.
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int MAX   = 150;

  typedef struct { int addr; logic [519:0] word; int due; } wr_t;
  typedef struct { int addr; int len; int due; } desc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_cnt, drop_cnt, err_cnt;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;
  bit          en_free = 1'b0;

  wr_t   exp_wr[$];
  desc_t exp_desc[$];
  int    outstanding[$];

  int m_ptr, m_start, m_len, m_occ, m_pkt, m_drop, m_err;
  bit m_in_pkt, m_discard, m_pend;

  esram_pkt_writer_if #(.AWIDTH(AW)) bus ();

  esram_pkt_writer #(.AWIDTH(AW), .MAX_PKT_FLITS(MAX), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [519:0] got, logic [519:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got %0h exp %0h", name, got, exp);
    else n_pass++;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_start = 0; m_len = 0; m_occ = 0;
    m_pkt = 0; m_drop = 0; m_err = 0;
    m_in_pkt = 0; m_discard = 0; m_pend = 0;
    outstanding.delete();
  endfunction

  function automatic void emit_write(logic [519:0] w);
    exp_wr.push_back('{addr: m_ptr, word: w, due: cyc + 1});
    m_ptr = (m_ptr + 1) % DEPTH;
  endfunction

  function automatic void finish_pkt();
    exp_desc.push_back('{addr: m_start, len: m_len, due: cyc + 1});
    m_pkt++;
    outstanding.push_back(m_len);
    m_in_pkt = 0;
  endfunction

  function automatic void model_step(bit v, bit s, bit e, logic [519:0] w,
                                     bit fv, int fl, bit af);
    int rewound = 0;
    int held;
    bit newp = 0, wrote = 0;
    if (v) begin
      if (m_in_pkt) begin
        if (s) begin
          m_err++; m_ptr = m_start; rewound = m_len; m_in_pkt = 0; newp = 1;
        end else if (m_len == MAX) begin
          m_err++; m_ptr = m_start; rewound = m_len; m_in_pkt = 0;
          m_discard = !e; m_pend = 0;
        end else begin
          emit_write(w); m_len++; wrote = 1;
          if (e) finish_pkt();
        end
      end else if (m_discard) begin
        if (s || e) begin
          if (m_pend) m_drop++;
          m_discard = 0; m_pend = 0;
        end
        newp = s;
      end else if (s) begin
        newp = 1;
      end else begin
        m_err++;
      end
      if (newp) begin
        if (DEPTH - (m_occ - rewound) >= MAX && !af) begin
          m_start = m_ptr; emit_write(w); m_len = 1; wrote = 1;
          if (e) finish_pkt(); else m_in_pkt = 1;
        end else if (e) begin
          m_drop++;
        end else begin
          m_discard = 1; m_pend = 1;
        end
      end
    end
    held = m_occ - rewound;
    if (fv) begin
      if (fl > held) begin m_err++; held = 0; end
      else held -= fl;
    end
    m_occ = held + (wrote ? 1 : 0);
  endfunction

  task automatic cycle(bit v, bit s, bit e, logic [5:0] emp, bit fv, int fl, bit af);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    bus.in_valid = v; bus.in_sop = s; bus.in_eop = e;
    bus.in_empty = emp; bus.in_data = d;
    bus.free_valid = fv; bus.free_len = AW'(fl); bus.desc_almost_full = af;
    model_step(v, s, e, {s, e, emp, d}, fv, fl, af);
    @(posedge clk); #1;
  endtask

  task automatic flit(bit v, bit s, bit e, logic [5:0] emp, bit af);
    bit fv = 0;
    int fl = 0;
    if (en_free && outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
      fv = 1; fl = outstanding.pop_front();
    end
    cycle(v, s, e, emp, fv, fl, af);
  endtask

  // emp_last < 0 picks a random empty count for the eop flit.
  task automatic send_pkt(int n, bit af_sop, bit af_mid, int gap_pct, bit no_eop, int emp_last);
    for (int i = 0; i < n; i++) begin
      bit last = (i == n - 1);
      logic [5:0] emp = '0;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) flit(0, 0, 0, '0, af_mid);
      if (last && !no_eop) emp = (emp_last < 0) ? 6'($urandom_range(0, 63)) : 6'(emp_last);
      flit(1, i == 0, last && !no_eop, emp, (i == 0) ? af_sop : af_mid);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) flit(0, 0, 0, '0, 0);
  endtask

  task automatic drain();
    while (outstanding.size() > 0) cycle(0, 0, 0, '0, 1, outstanding.pop_front(), 0);
    idle(2);
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_empty = '0; bus.in_data = '0;
    bus.free_valid = 0; bus.free_len = '0; bus.desc_almost_full = 0;
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic check_counters(string tag);
    chk({tag, "_pkt_cnt"},  520'(pkt_cnt),  520'(m_pkt));
    chk({tag, "_drop_cnt"}, 520'(drop_cnt), 520'(m_drop));
    chk({tag, "_err_cnt"},  520'(err_cnt),  520'(m_err));
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_wren"},     520'(bus.esram_pkt_buf_wren), '0);
    chk({tag, "_wraddr"},   520'(bus.esram_pkt_buf_wraddress), '0);
    chk({tag, "_wrdata"},   bus.esram_pkt_buf_wrdata, '0);
    chk({tag, "_dvalid"},   520'(bus.desc_valid), '0);
    chk({tag, "_daddr"},    520'(bus.desc_addr), '0);
    chk({tag, "_dlen"},     520'(bus.desc_len), '0);
    chk({tag, "_pkt_cnt"},  520'(pkt_cnt), '0);
    chk({tag, "_drop_cnt"}, 520'(drop_cnt), '0);
    chk({tag, "_err_cnt"},  520'(err_cnt), '0);
  endtask

  initial begin : monitor
    wr_t   ew;
    desc_t ed;
    forever begin
      @(negedge clk);
      if (bus.esram_pkt_buf_wren === 1'b1) begin
        if (exp_wr.size() == 0) chk("unexpected_wren", 520'(1), 520'(0));
        else begin
          ew = exp_wr.pop_front();
          chk("wr_cycle", 520'(cyc), 520'(ew.due));
          chk("wr_addr", 520'(bus.esram_pkt_buf_wraddress), 520'(ew.addr));
          chk("wr_data", bus.esram_pkt_buf_wrdata, ew.word);
        end
      end else if (exp_wr.size() > 0 && exp_wr[0].due <= cyc) begin
        ew = exp_wr.pop_front();
        chk("missing_wren", 520'(0), 520'(1));
      end
      if (bus.desc_valid === 1'b1) begin
        if (exp_desc.size() == 0) chk("unexpected_desc", 520'(1), 520'(0));
        else begin
          ed = exp_desc.pop_front();
          chk("desc_cycle", 520'(cyc), 520'(ed.due));
          chk("desc_addr", 520'(bus.desc_addr), 520'(ed.addr));
          chk("desc_len", 520'(bus.desc_len), 520'(ed.len));
        end
      end else if (exp_desc.size() > 0 && exp_desc[0].due <= cyc) begin
        ed = exp_desc.pop_front();
        chk("missing_desc", 520'(0), 520'(1));
      end
    end
  end

  initial begin : stimulus
    int base;
    do_reset();
    check_outputs_zero("reset");

    // Single-flit packet straight out of reset.
    send_pkt(1, 0, 0, 0, 0, 10);
    idle(2);
    chk("one_flit_pkt_cnt", 520'(pkt_cnt), 520'(1));
    check_counters("one_flit");

    // Back-to-back 3-flit packets.
    do_reset();
    send_pkt(3, 0, 0, 0, 0, -1);
    send_pkt(3, 0, 0, 0, 0, -1);
    idle(2);
    chk("b2b_pkt_cnt", 520'(pkt_cnt), 520'(2));

    // Walk the pointer to DEPTH-2, then a 4-flit packet straddles the wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_pkt(102, 0, 0, 0, 0, -1);
      drain();
    end
    send_pkt(4, 0, 0, 0, 0, -1);
    idle(2);
    drain();
    check_counters("wrap");

    // Fill to exactly the admit limit, one more packet fits, the next is dropped.
    do_reset();
    send_pkt(150, 0, 0, 0, 0, -1);
    send_pkt(150, 0, 0, 0, 0, -1);
    send_pkt(62, 0, 0, 0, 0, -1);
    send_pkt(10, 0, 0, 0, 0, -1);
    base = int'(drop_cnt);
    send_pkt(5, 0, 0, 0, 0, -1);
    idle(2);
    chk("full_drop", 520'(drop_cnt), 520'(base + 1));
    chk("full_pkt_cnt", 520'(pkt_cnt), 520'(4));
    drain();
    send_pkt(8, 0, 0, 0, 0, -1);
    idle(2);
    chk("after_free_pkt_cnt", 520'(pkt_cnt), 520'(5));
    check_counters("full");

    // Descriptor credit: refused at sop, ignored mid-packet.
    base = int'(drop_cnt);
    send_pkt(4, 1, 0, 0, 0, -1);
    idle(1);
    chk("afull_sop_drop", 520'(drop_cnt), 520'(base + 1));
    base = int'(pkt_cnt);
    send_pkt(6, 0, 1, 0, 0, -1);
    idle(2);
    chk("afull_mid_stored", 520'(pkt_cnt), 520'(base + 1));
    drain();

    // Missing eop: new packet overwrites from the old start.
    do_reset();
    send_pkt(2, 0, 0, 0, 1, -1);
    send_pkt(3, 0, 0, 0, 0, -1);
    idle(2);
    chk("missing_eop_err", 520'(err_cnt), 520'(1));
    check_counters("missing_eop");

    // Oversize packet aborted; maximum length still stored.
    base = int'(err_cnt);
    send_pkt(151, 0, 0, 0, 0, -1);
    idle(1);
    chk("oversize_err", 520'(err_cnt), 520'(base + 1));
    send_pkt(150, 0, 0, 0, 0, -1);
    idle(2);
    check_counters("oversize");
    drain();

    // Stray non-sop flit while idle.
    base = int'(err_cnt);
    flit(1, 0, 1, '0, 0);
    chk("stray_err", 520'(err_cnt), 520'(base + 1));

    // Returning more space than is held.
    do_reset();
    cycle(0, 0, 0, '0, 1, 50, 0);
    chk("overfree_err", 520'(err_cnt), 520'(1));

    // Reset in the middle of a packet.
    do_reset();
    send_pkt(3, 0, 0, 0, 1, -1);
    do_reset();
    check_outputs_zero("midrst");
    send_pkt(2, 0, 0, 0, 0, -1);
    idle(2);
    check_counters("midrst");

    // Randomized traffic.
    do_reset();
    en_free = 1;
    for (int p = 0; p < 300; p++) begin
      int n = ($urandom_range(0, 49) == 0) ? $urandom_range(148, 153) : $urandom_range(1, 24);
      send_pkt(n, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
               20, $urandom_range(0, 19) == 0, -1);
      if ($urandom_range(0, 29) == 0) flit(1, 0, $urandom_range(0, 1) == 1, '0, 0);
    end
    idle(3);
    check_counters("random");
    en_free = 0;
    drain();
    idle(3);
    chk("wr_queue_empty", 520'(exp_wr.size()), 520'(0));
    chk("desc_queue_empty", 520'(exp_desc.size()), 520'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
